// File: rtl/prf_free_list_ctrl.sv
// rtl/prf_free_list_ctrl.sv - circular free list of physical register numbers with speculative and committed heads
//
// Purpose:
//   Hands out free physical register numbers (PRNs) to rename and takes back
//   released PRNs from ROB commit. Rename consumes entries at spec_head. Commit
//   advances commit_head and writes the released PRN at tail. A flush rolls
//   spec_head back to commit_head, so speculatively handed-out PRNs return to
//   the pool in their original order.
//   tail - commit_head is always MAX_FREE_REGS.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   alloc_req       rename wants one PRN this cycle
//   alloc_gnt       PRN granted this cycle (combinational)
//   alloc_prn       PRN at the speculative head (valid with alloc_gnt)
//   commit_valid    retiring instruction releases commit_p_old
//   commit_p_old    PRN being released
//   flush           squash all speculative allocations
//   free_count      PRNs available to rename
//   inflight_count  PRNs allocated but not yet committed
//   empty           no PRN available
//   err             sticky: commit seen with nothing in flight

module prf_free_list_ctrl #(
    parameter int  NUM_A_REGS    = 32,
    parameter int  ROB_SIZE      = 16,
    localparam int NUM_P_REGS    = ROB_SIZE + NUM_A_REGS,
    localparam int MAX_FREE_REGS = NUM_P_REGS - NUM_A_REGS,
    localparam int PRN_WIDTH     = $clog2(NUM_P_REGS),
    localparam int PTR_W         = $clog2(MAX_FREE_REGS) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 alloc_req,
    output logic                 alloc_gnt,
    output logic [PRN_WIDTH-1:0] alloc_prn,
    input  logic                 commit_valid,
    input  logic [PRN_WIDTH-1:0] commit_p_old,
    input  logic                 flush,
    output logic [PTR_W-1:0]     free_count,
    output logic [PTR_W-1:0]     inflight_count,
    output logic                 empty,
    output logic                 err
);

    localparam int IDX_W = PTR_W - 1;

    logic [PRN_WIDTH-1:0] entry_q [MAX_FREE_REGS];
    logic [PRN_WIDTH-1:0] entry_d [MAX_FREE_REGS];
    logic [PTR_W-1:0]     spec_head_q, spec_head_d;
    logic [PTR_W-1:0]     commit_head_q, commit_head_d;
    logic [PTR_W-1:0]     tail_q, tail_d;
    logic                 err_q, err_d;

    logic                 commit_ok;

    // Counts come straight from pointer differences; the wrap bit makes a
    // full buffer (difference MAX_FREE_REGS) distinct from an empty one.
    always_comb begin
        free_count     = tail_q - spec_head_q;
        inflight_count = spec_head_q - commit_head_q;
        empty          = (free_count == '0);
        alloc_prn      = entry_q[spec_head_q[IDX_W-1:0]];
        // Grant looks only at registered state, so a PRN released this
        // cycle is never handed out in the same cycle.
        alloc_gnt      = alloc_req & ~empty & ~flush;
        err            = err_q;
    end

    always_comb begin
        commit_ok = commit_valid & (inflight_count != '0);

        entry_d       = entry_q;
        tail_d        = tail_q;
        commit_head_d = commit_head_q;
        spec_head_d   = spec_head_q;
        err_d         = err_q | (commit_valid & (inflight_count == '0));

        if (commit_ok) begin
            entry_d[tail_q[IDX_W-1:0]] = commit_p_old;
            tail_d                     = tail_q + 1'b1;
            commit_head_d              = commit_head_q + 1'b1;
        end

        // Rollback targets the post-commit head so a same-cycle commit is
        // not undone by the flush.
        if (flush) begin
            spec_head_d = commit_head_d;
        end else if (alloc_gnt) begin
            spec_head_d = spec_head_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < MAX_FREE_REGS; i++) begin
                entry_q[i] <= PRN_WIDTH'(NUM_A_REGS + i);
            end
            spec_head_q   <= '0;
            commit_head_q <= '0;
            tail_q        <= PTR_W'(MAX_FREE_REGS);
            err_q         <= 1'b0;
        end else begin
            entry_q       <= entry_d;
            spec_head_q   <= spec_head_d;
            commit_head_q <= commit_head_d;
            tail_q        <= tail_d;
            err_q         <= err_d;
        end
    end

endmodule
